// File: rtl/switch_mcu_ex_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : switch_mcu_ex_pkg
//  Purpose  : Shared definitions for the switch MCU execute unit. Holds the
//             op-code constants, the FSM state encoding and the
//             illegal-operation and shift-class predicates.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package switch_mcu_ex_pkg;

    // Operation codes carried on in_op.
    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] SLL  = 4'd2;
    localparam logic [3:0] SLT  = 4'd3;
    localparam logic [3:0] SLTU = 4'd4;
    localparam logic [3:0] XOR  = 4'd5;
    localparam logic [3:0] SRL  = 4'd6;
    localparam logic [3:0] SRA  = 4'd7;
    localparam logic [3:0] OR   = 4'd8;
    localparam logic [3:0] AND  = 4'd9;

    // FSM state encoding.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_READ  = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_EXEC  = 3'd3;
    localparam state_t S_WRITE = 3'd4;

    // Codes above AND are unassigned; SUB has no immediate form.
    function automatic logic is_illegal(input logic [3:0] op, input logic src2_imm);
        return (op > AND) || ((op == SUB) && src2_imm);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == SLL) || (op == SRL) || (op == SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_mcu_ex_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : switch_mcu_ex_alu_if
//  Purpose  : Request / register-file bundle between the decoder side and
//             the execute unit.
//  Ports    : master - decoder/register-file side (drives in_*)
//             slave  - execute unit (drives out_*)
//  Revision : 1.0 - initial release
// ============================================================================
interface switch_mcu_ex_alu_if #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
);
    logic             in_start;
    logic [3:0]       in_op;
    logic             in_src2_imm;
    logic [11:0]      in_imm;
    logic [RF_AW-1:0] in_rs1;
    logic [RF_AW-1:0] in_rs2;
    logic [RF_AW-1:0] in_rd;
    logic             out_ren_1;
    logic             out_ren_2;
    logic [RF_AW-1:0] out_raddr_1;
    logic [RF_AW-1:0] out_raddr_2;
    logic [XLEN-1:0]  in_rdata_1;
    logic [XLEN-1:0]  in_rdata_2;
    logic             out_wen;
    logic [RF_AW-1:0] out_waddr;
    logic [XLEN-1:0]  out_wdata;
    logic             out_busy;
    logic             out_done;
    logic             out_illegal;

    modport master (
        output in_start, in_op, in_src2_imm, in_imm, in_rs1, in_rs2, in_rd,
        output in_rdata_1, in_rdata_2,
        input  out_ren_1, out_ren_2, out_raddr_1, out_raddr_2,
        input  out_wen, out_waddr, out_wdata, out_busy, out_done, out_illegal
    );

    modport slave (
        input  in_start, in_op, in_src2_imm, in_imm, in_rs1, in_rs2, in_rd,
        input  in_rdata_1, in_rdata_2,
        output out_ren_1, out_ren_2, out_raddr_1, out_raddr_2,
        output out_wen, out_waddr, out_wdata, out_busy, out_done, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/switch_mcu_ex_alu_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : switch_mcu_ex_shifter
//  Purpose  : Shift unit for SLL/SRL/SRA with a start/done handshake.
//             Macro SWITCH_MCU_EX_SERIAL_SHIFT_EN selects a 1-bit-per-cycle
//             shifter (done after max(shamt,1) cycles); otherwise a barrel
//             shifter answers in the start cycle.
//  Ports    : in_clk, in_rst (async, active-low)
//             start_i  - first EXEC cycle of a shift
//             left_i   - SLL;  arith_i - SRA
//             a_i, shamt_i - operand and shift amount
//             done_o   - result valid this cycle;  res_o - result
//  Revision : 1.0 - initial release
// ============================================================================
module switch_mcu_ex_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  wire logic            in_clk,
    input  wire logic            in_rst,
    input  wire logic            start_i,
    input  wire logic            left_i,
    input  wire logic            arith_i,
    input  wire logic [XLEN-1:0] a_i,
    input  wire logic [SHW-1:0]  shamt_i,
    output logic                 done_o,
    output logic [XLEN-1:0]      res_o
);

`ifdef SWITCH_MCU_EX_SERIAL_SHIFT_EN

    logic [XLEN-1:0] val_q;
    logic [SHW-1:0]  cnt_q;
    logic            act_q;
    logic            left_q;
    logic            sign_q;
    logic            w_fill;

    function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v,
                                               input logic left,
                                               input logic fill);
        return left ? {v[XLEN-2:0], 1'b0} : {fill, v[XLEN-1:1]};
    endfunction

    assign w_fill = arith_i & a_i[XLEN-1];

    // The start cycle performs the first step itself, so an N-bit shift
    // finishes in N cycles and a 0/1-bit shift finishes in one.
    always_comb begin
        if (start_i) begin
            done_o = (shamt_i <= SHW'(1));
            res_o  = (shamt_i == '0) ? a_i : shift1(a_i, left_i, w_fill);
        end else begin
            done_o = act_q && (cnt_q == SHW'(1));
            res_o  = shift1(val_q, left_q, sign_q);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            val_q  <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            left_q <= 1'b0;
            sign_q <= 1'b0;
        end else if (start_i) begin
            if (shamt_i > SHW'(1)) begin
                act_q  <= 1'b1;
                val_q  <= shift1(a_i, left_i, w_fill);
                cnt_q  <= shamt_i - SHW'(1);
                left_q <= left_i;
                sign_q <= w_fill;
            end
        end else if (act_q) begin
            val_q <= shift1(val_q, left_q, sign_q);
            cnt_q <= cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                act_q <= 1'b0;
            end
        end
    end

`else

    logic unused_clk_rst;
    assign unused_clk_rst = ^{in_clk, in_rst};

    always_comb begin
        done_o = start_i;
        if (left_i) begin
            res_o = a_i << shamt_i;
        end else if (arith_i) begin
            res_o = $signed(a_i) >>> shamt_i;
        end else begin
            res_o = a_i >> shamt_i;
        end
    end

`endif

endmodule
`default_nettype wire

// File: rtl/switch_mcu_ex_alu.sv
`default_nettype none
// ============================================================================
//  Module   : switch_mcu_ex_alu
//  Purpose  : Integer execute unit. Accepts one request, reads rs1/rs2 from
//             the register file, computes the ALU result and writes rd.
//             FSM: IDLE -> READ -> WAIT(RD_LAT-1) -> EXEC -> WRITE.
//             Macro SWITCH_MCU_EX_SERIAL_SHIFT_EN selects the serial shifter.
//  Ports    : in_clk  - clock
//             in_rst  - asynchronous active-low reset
//             bus     - switch_mcu_ex_alu_if.slave (request, RF read/write,
//                       busy/done/illegal status)
//  Revision : 1.0 - initial release
// ============================================================================
module switch_mcu_ex_alu
    import switch_mcu_ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RF_AW  = 5,
    parameter int RD_LAT = 2
) (
    input  wire logic            in_clk,
    input  wire logic            in_rst,
    switch_mcu_ex_alu_if.slave   bus
);

    localparam int SHW = $clog2(XLEN);

    state_t           state_q, state_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic             exec_first_q;
    logic [3:0]       op_q;
    logic             src2_imm_q;
    logic [11:0]      imm_q;
    logic [RF_AW-1:0] rs1_q, rs2_q, rd_q;
    logic             illegal_q;
    logic [XLEN-1:0]  result_q, result_d;

    logic             w_accept;
    logic [XLEN-1:0]  w_op1, w_op2, w_alu, w_sh_res;
    logic             w_sh_path, w_sh_start, w_sh_done;

    assign w_accept = (state_q == S_IDLE) && bus.in_start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            exec_first_q <= (state_d == S_EXEC) && (state_q != S_EXEC);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_start) state_d = S_READ;
            end
            S_READ: begin
                if (RD_LAT > 1) begin
                    state_d = S_WAIT;
                    wcnt_d  = 2'(RD_LAT - 2);
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 2'd0) state_d = S_EXEC;
                else                wcnt_d  = wcnt_q - 2'd1;
            end
            S_EXEC: begin
                if (!w_sh_path || w_sh_done) state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.out_ren_1   = 1'b0;
        bus.out_ren_2   = 1'b0;
        bus.out_raddr_1 = '0;
        bus.out_raddr_2 = '0;
        bus.out_wen     = 1'b0;
        bus.out_waddr   = '0;
        bus.out_wdata   = '0;
        bus.out_done    = 1'b0;
        bus.out_illegal = 1'b0;
        bus.out_busy    = (state_q != S_IDLE);
        case (state_q)
            S_READ: begin
                bus.out_ren_1   = 1'b1;
                bus.out_raddr_1 = rs1_q;
                if (!src2_imm_q) begin
                    bus.out_ren_2   = 1'b1;
                    bus.out_raddr_2 = rs2_q;
                end
            end
            S_WRITE: begin
                bus.out_done    = 1'b1;
                bus.out_illegal = illegal_q;
                // x0 is never written, but the result stays visible.
                if (!illegal_q) begin
                    bus.out_wdata = result_q;
                    if (rd_q != '0) begin
                        bus.out_wen   = 1'b1;
                        bus.out_waddr = rd_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- request latch and result register ----------------
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            op_q       <= '0;
            src2_imm_q <= 1'b0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            illegal_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            if (w_accept) begin
                op_q       <= bus.in_op;
                src2_imm_q <= bus.in_src2_imm;
                imm_q      <= bus.in_imm;
                rs1_q      <= bus.in_rs1;
                rs2_q      <= bus.in_rs2;
                rd_q       <= bus.in_rd;
                illegal_q  <= is_illegal(bus.in_op, bus.in_src2_imm);
            end
            result_q <= result_d;
        end
    end

    // ---------------- datapath ----------------
    assign w_op1 = bus.in_rdata_1;
    assign w_op2 = src2_imm_q ? {{(XLEN-12){imm_q[11]}}, imm_q} : bus.in_rdata_2;

    always_comb begin
        w_alu = '0;
        case (op_q)
            ADD:  w_alu = w_op1 + w_op2;
            SUB:  w_alu = w_op1 - w_op2;
            SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            SLTU: w_alu = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            XOR:  w_alu = w_op1 ^ w_op2;
            OR:   w_alu = w_op1 | w_op2;
            AND:  w_alu = w_op1 & w_op2;
            default: w_alu = '0;
        endcase
    end

    // Illegal operations never reach the shifter, so they finish in one
    // EXEC cycle with a zero result.
    assign w_sh_path  = is_shift(op_q) && !illegal_q;
    assign w_sh_start = (state_q == S_EXEC) && exec_first_q && w_sh_path;

    switch_mcu_ex_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .in_clk  (in_clk),
        .in_rst  (in_rst),
        .start_i (w_sh_start),
        .left_i  (op_q == SLL),
        .arith_i (op_q == SRA),
        .a_i     (w_op1),
        .shamt_i (w_op2[SHW-1:0]),
        .done_o  (w_sh_done),
        .res_o   (w_sh_res)
    );

    // Read data is only valid in the first EXEC cycle; later cycles wait
    // on the shifter, which holds its own copy of the operand.
    always_comb begin
        result_d = result_q;
        if (state_q == S_EXEC) begin
            if (w_sh_path) begin
                if (w_sh_done) result_d = w_sh_res;
            end else if (exec_first_q) begin
                result_d = illegal_q ? '0 : w_alu;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_mcu_ex_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_mcu_ex_alu
//  Purpose  : Self-checking bench. Four execute units (RD_LAT 1/2/4 at
//             XLEN=32 and RD_LAT 2 at XLEN=64) receive the same requests;
//             every output is compared each cycle against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_switch_mcu_ex_alu;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic        simm;
    logic [11:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] rf [32];

    logic        busy_a [NI], done_a [NI], ill_a [NI], wen_a [NI];
    logic        ren1_a [NI], ren2_a [NI];
    logic [4:0]  waddr_a [NI], raddr1_a [NI], raddr2_a [NI];
    logic [63:0] wdata_a [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int X = (g == 3) ? 64 : 32;
        localparam int L = (g == 0) ? 1 : (g == 2) ? 4 : 2;

        switch_mcu_ex_alu_if #(.XLEN(X), .RF_AW(5)) bus ();
        logic [63:0] p1 [4];
        logic [63:0] p2 [4];

        assign bus.in_start    = start;
        assign bus.in_op       = op;
        assign bus.in_src2_imm = simm;
        assign bus.in_imm      = imm;
        assign bus.in_rs1      = rs1;
        assign bus.in_rs2      = rs2;
        assign bus.in_rd       = rd;
        assign bus.in_rdata_1  = p1[L-1][X-1:0];
        assign bus.in_rdata_2  = p2[L-1][X-1:0];

        // Register file: data appears L cycles after the read edge, zero
        // when no read was issued.
        always_ff @(posedge clk) begin
            p1[0] <= bus.out_ren_1 ? rf[bus.out_raddr_1] : 64'h0;
            p2[0] <= bus.out_ren_2 ? rf[bus.out_raddr_2] : 64'h0;
            for (int k = 1; k < 4; k++) begin
                p1[k] <= p1[k-1];
                p2[k] <= p2[k-1];
            end
        end

        switch_mcu_ex_alu #(.XLEN(X), .RF_AW(5), .RD_LAT(L)) u_dut (
            .in_clk (clk),
            .in_rst (rst_n),
            .bus    (bus)
        );

        assign busy_a[g]   = bus.out_busy;
        assign done_a[g]   = bus.out_done;
        assign ill_a[g]    = bus.out_illegal;
        assign wen_a[g]    = bus.out_wen;
        assign waddr_a[g]  = bus.out_waddr;
        assign wdata_a[g]  = 64'(bus.out_wdata);
        assign ren1_a[g]   = bus.out_ren_1;
        assign ren2_a[g]   = bus.out_ren_2;
        assign raddr1_a[g] = bus.out_raddr_1;
        assign raddr2_a[g] = bus.out_raddr_2;
    end

    // {busy,done,illegal,wen,waddr,wdata,ren1,raddr1,ren2,raddr2}
    function automatic logic [84:0] pack(logic b, logic d, logic il, logic w,
                                         logic [4:0] wa, logic [63:0] wd,
                                         logic r1, logic [4:0] a1,
                                         logic r2, logic [4:0] a2);
        return {b, d, il, w, wa, wd, r1, a1, r2, a2};
    endfunction

    function automatic logic [84:0] actual(int g);
        return pack(busy_a[g], done_a[g], ill_a[g], wen_a[g], waddr_a[g],
                    wdata_a[g], ren1_a[g], raddr1_a[g], ren2_a[g], raddr2_a[g]);
    endfunction

    task automatic chk(string name, logic [84:0] act, logic [84:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {illegal, result} computed directly from the op rules.
    function automatic logic [64:0] ref_op(int xl, logic [3:0] o, logic si,
                                           logic [11:0] im, logic [63:0] a_in,
                                           logic [63:0] b_in);
        logic [63:0] mask, a, b, r;
        logic        ill;
        int          sh;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a    = a_in & mask;
        b    = (si ? {{52{im[11]}}, im} : b_in) & mask;
        sh   = int'(b[5:0]) & (xl - 1);
        ill  = 1'b0;
        r    = 64'h0;
        case (o)
            4'd0: r = a + b;
            4'd1: if (si) ill = 1'b1; else r = a - b;
            4'd2: r = a << sh;
            4'd3: r = (xl == 32) ? {63'h0, $signed(a[31:0]) < $signed(b[31:0])}
                                 : {63'h0, $signed(a) < $signed(b)};
            4'd4: r = {63'h0, a < b};
            4'd5: r = a ^ b;
            4'd6: r = a >> sh;
            4'd7: r = (xl == 32) ? {32'h0, 32'($signed(a[31:0]) >>> sh)}
                                 : 64'($signed(a) >>> sh);
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: ill = 1'b1;
        endcase
        r = ill ? 64'h0 : (r & mask);
        return {ill, r};
    endfunction

    // Caller is at a negedge. Drives one request and checks all instances
    // every cycle until two cycles past the slowest completion.
    task automatic run_op(logic [3:0] o, logic si, logic [11:0] im,
                          logic [4:0] a1, logic [4:0] a2, logic [4:0] d,
                          bit have_exp, logic [63:0] exp32, int inj1, int inj2);
        logic [64:0] r;
        logic [63:0] res_e [NI];
        logic        ill_e [NI];
        int          dd [NI];
        int          maxd;
        int          xl, ll;
        logic        wen_e;
        logic [84:0] e;
        maxd = 0;
        for (int g = 0; g < NI; g++) begin
            xl = (g == 3) ? 64 : 32;
            ll = (g == 0) ? 1 : (g == 2) ? 4 : 2;
            r  = ref_op(xl, o, si, im, rf[a1], rf[a2]);
            ill_e[g] = r[64];
            res_e[g] = (have_exp && xl == 32) ? exp32 : r[63:0];
            dd[g]    = ll + 2;
`ifdef SWITCH_MCU_EX_SERIAL_SHIFT_EN
            begin
                logic [63:0] b;
                int          sh;
                b  = si ? {{52{im[11]}}, im} : rf[a2];
                sh = int'(b[5:0]) & (xl - 1);
                if (!ill_e[g] && (o == 4'd2 || o == 4'd6 || o == 4'd7))
                    dd[g] = ll + 1 + ((sh > 0) ? sh : 1);
            end
`endif
            if (dd[g] > maxd) maxd = dd[g];
        end
        op = o; simm = si; imm = im; rs1 = a1; rs2 = a2; rd = d; start = 1'b1;
        for (int n = 1; n <= maxd + 2; n++) begin
            @(negedge clk);
            start = (n == inj1) || (n == inj2);
            for (int g = 0; g < NI; g++) begin
                wen_e = (n == dd[g]) && !ill_e[g] && (d != 5'd0);
                e = pack(n <= dd[g], n == dd[g], (n == dd[g]) && ill_e[g], wen_e,
                         wen_e ? d : 5'd0,
                         ((n == dd[g]) && !ill_e[g]) ? res_e[g] : 64'h0,
                         n == 1, (n == 1) ? a1 : 5'd0,
                         (n == 1) && !si, ((n == 1) && !si) ? a2 : 5'd0);
                chk($sformatf("op%0d i%0d c%0d", o, g, n), actual(g), e);
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        si;
        logic [11:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{4'd0, 1'b1, 12'hFFF, 5'd5, 5'd0, 5'd6,  32'h0000_000F};
        tbl[1]  = '{4'd1, 1'b0, 12'h000, 5'd1, 5'd2, 5'd7,  32'hFFFF_FFFE};
        tbl[2]  = '{4'd4, 1'b1, 12'hFFF, 5'd1, 5'd0, 5'd8,  32'h0000_0001};
        tbl[3]  = '{4'd3, 1'b0, 12'h000, 5'd3, 5'd8, 5'd9,  32'h0000_0001};
        tbl[4]  = '{4'd7, 1'b1, 12'd31,  5'd3, 5'd0, 5'd10, 32'hFFFF_FFFF};
        tbl[5]  = '{4'd7, 1'b1, 12'd0,   5'd3, 5'd0, 5'd10, 32'h8000_0000};
        tbl[6]  = '{4'd0, 1'b0, 12'h000, 5'd1, 5'd2, 5'd0,  32'h0000_0008};
        tbl[7]  = '{4'd1, 1'b1, 12'h001, 5'd1, 5'd0, 5'd4,  32'h0000_0000};
        tbl[8]  = '{4'd12,1'b0, 12'h000, 5'd1, 5'd2, 5'd4,  32'h0000_0000};
        tbl[9]  = '{4'd0, 1'b1, 12'h800, 5'd5, 5'd0, 5'd11, 32'hFFFF_F810};
        tbl[10] = '{4'd5, 1'b0, 12'h000, 5'd9, 5'd2, 5'd12, 32'h9ABC_DEF5};
        tbl[11] = '{4'd2, 1'b1, 12'd4,   5'd9, 5'd0, 5'd13, 32'hABCD_EF00};
        tbl[12] = '{4'd6, 1'b0, 12'h000, 5'd9, 5'd1, 5'd14, 32'h1357_9BDE};
        tbl[13] = '{4'd8, 1'b1, 12'h00F, 5'd5, 5'd0, 5'd15, 32'h0000_001F};
        tbl[14] = '{4'd9, 1'b1, 12'h0FF, 5'd9, 5'd0, 5'd16, 32'h0000_00F0};

        for (int i = 0; i < 32; i++) rf[i] = 64'h0;
        rf[1] = 64'd3;
        rf[2] = 64'd5;
        rf[3] = 64'h0000_0000_8000_0000;
        rf[5] = 64'h10;
        rf[8] = 64'd1;
        rf[9] = 64'h1234_5678_9ABC_DEF0;

        rst_n = 1'b0; start = 1'b0; op = '0; simm = 1'b0; imm = '0;
        rs1 = '0; rs2 = '0; rd = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) chk($sformatf("reset i%0d", g), actual(g), 85'h0);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 15; i++)
            run_op(tbl[i].op, tbl[i].si, tbl[i].imm, tbl[i].rs1, tbl[i].rs2,
                   tbl[i].rd, 1'b1, {32'h0, tbl[i].exp}, 0, 0);

        // Start re-asserted in READ (cycle 1) and in EXEC of the RD_LAT=2 unit.
        run_op(tbl[0].op, tbl[0].si, tbl[0].imm, tbl[0].rs1, tbl[0].rs2,
               tbl[0].rd, 1'b1, {32'h0, tbl[0].exp}, 1, 3);

        // Asynchronous reset during WAIT, then an immediate new request.
        op = 4'd0; simm = 1'b1; imm = 12'h123; rs1 = 5'd5; rd = 5'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) chk($sformatf("midrst i%0d", g), actual(g), 85'h0);
        repeat (2) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) chk($sformatf("inrst i%0d", g), actual(g), 85'h0);
        end
        rst_n = 1'b1;
        run_op(tbl[1].op, tbl[1].si, tbl[1].imm, tbl[1].rs1, tbl[1].rs2,
               tbl[1].rd, 1'b1, {32'h0, tbl[1].exp}, 0, 0);

        // Randomized operations against the reference model.
        for (int t = 0; t < 40; t++) begin
            for (int i = 1; i < 32; i++) rf[i] = {$urandom, $urandom};
            run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   12'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   1'b0, 64'h0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_mcu_ex_alu.md
# switch_mcu_ex_alu

Parametrised integer execute unit for the switch MCU core. It handles register-register and register-immediate ALU operations, and runs its own start/done state machine, so it no longer depends on an external cycle counter. It sits between the decoder and the register file. It issues up to two register-file reads and one write per operation.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 or 64.
- RF_AW, 5: register-file address width.
- RD_LAT, 2: register-file read latency in cycles; legal range 1..4.

Ports:
- in_clk  in  1  clock.
- in_rst  in  1  reset, asynchronous, active-low.
- in_start  in  1  single-cycle request; sampled only in IDLE.
- in_op  in  4  operation code, see Structure.
- in_src2_imm  in  1  1: operand 2 is the immediate; 0: operand 2 is rs2.
- in_imm  in  12  I-type immediate.
- in_rs1, in_rs2, in_rd  in  RF_AW  register indices.
- out_ren_1, out_ren_2  out  1  read enables.
- out_raddr_1, out_raddr_2  out  RF_AW  read addresses.
- in_rdata_1, in_rdata_2  in  XLEN  read data.
- out_wen  out  1  write enable.
- out_waddr  out  RF_AW  write address.
- out_wdata  out  XLEN  write data.
- out_busy  out  1  high in every state except IDLE.
- out_done  out  1  single-cycle completion pulse.
- out_illegal  out  1  single-cycle pulse, coincident with out_done, for an illegal operation.

## Operation
- FSM states: IDLE, READ, WAIT, EXEC, WRITE.
- IDLE to READ: on in_start. In the same edge, latch op, src2_imm, imm, rs1, rs2 and rd.
- READ (1 cycle):
  - out_ren_1=1 with out_raddr_1=rs1.
  - out_ren_2=1 with out_raddr_2=rs2, only when src2_imm=0.
- WAIT: lasts RD_LAT-1 cycles and is skipped when RD_LAT=1. All enables are 0.
- EXEC: samples in_rdata_1 and in_rdata_2, then registers the result. Takes 1 cycle, except for serial shifts (see Configuration).
- WRITE (1 cycle):
  - out_wen=1, out_waddr=rd, out_wdata=result, out_done=1.
  - Next state is IDLE.
- Operand 2 is either the immediate sign-extended to XLEN or in_rdata_2.
- Shift amount is the low $clog2(XLEN) bits of operand 2.
- SLT and SLTU produce 0 or 1, zero-extended. SLTU compares the sign-extended immediate as an unsigned value.
- All arithmetic wraps modulo 2^XLEN, with no overflow flag.
- rd=0: out_wen stays 0 in WRITE. out_done still pulses and out_wdata carries the result.
- Illegal operation: in_op codes 10..15, or SUB with src2_imm=1.
  - out_wen=0, out_wdata=0.
  - out_illegal=1 together with out_done.
- in_start while busy: ignored. No queueing, no error.
- Outside the cycles listed above, every output is 0. Address and data outputs are zeroed whenever their enable is low.

## Timing
- Reset: every output is 0 and the FSM is in IDLE.
- Reset asserted mid-operation: abort immediately with no write. in_start is accepted again on the first edge after release.
- Combinational (non-serial) path: out_done and out_wen are high during cycle RD_LAT+2 after the edge that accepted in_start. With RD_LAT=2 this is 4 cycles.
- Back-to-back operations: a new in_start is accepted in the cycle after WRITE. Minimum throughput is one operation per RD_LAT+3 cycles.
- out_busy is high from the cycle after acceptance through WRITE inclusive.
- No combinational path from any input to any output.

## Configuration
- Macro: SWITCH_MCU_EX_SERIAL_SHIFT_EN.
- Defined:
  - SLL, SRL and SRA use a 1-bit-per-cycle shifter. EXEC lasts max(shamt,1) cycles.
  - Latency is RD_LAT+1+max(shamt,1).
  - SRA fills with the latched sign bit.
- Undefined:
  - Single-cycle barrel shifter; EXEC is always 1 cycle.
- Results are identical in both builds; only latency differs.

## Structure
- Package switch_mcu_ex_pkg holds:
  - Op-code localparams: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - The FSM state encoding.
  - The illegal-operation predicate as a function.
- Sub-module switch_mcu_ex_shifter: contains the barrel shifter or the serial shifter, selected by the macro. It has a start/done handshake toward the FSM.

## Test plan
- ADDI, rs1=5 holding 0x0000_0010, imm=0xFFF, rd=6, RD_LAT=2 -> out_wen=1 at cycle 4, waddr=6, wdata=0x0000_000F, done=1.
- SUB in R-type: 3 - 5 -> wdata=0xFFFF_FFFE. SLTU, 3 vs imm 0xFFF -> 1. SLT, 0x8000_0000 vs 1 -> 1.
- SRAI, 0x8000_0000 by 31:
  - Combinational build: wdata=0xFFFF_FFFF with done at cycle 4.
  - Serial build: done at cycle 34.
  - Shift amount 0 in the serial build: done at cycle 4.
- rd=0 -> done=1, wen=0. SUB with src2_imm=1 -> illegal=1, wen=0, wdata=0. Op 12 -> illegal=1.
- in_start pulsed during READ and again during EXEC -> ignored, exactly one write. Reset asserted during WAIT -> all outputs 0, no write, next start completes normally.
- RD_LAT=1 and RD_LAT=4, and XLEN=64 ADDI with imm=0x800 -> done at cycles 3 and 6; 64-bit wdata=rs1+0xFFFF_FFFF_FFFF_F800.
